mips_cpu_bus_master: RTL and testbench

Bus initiator for the MIPS CPU's memory port. It takes one load/store request at a time from the core (byte, half or word; signed or unsigned). It drives a word-aligned read or write with `byteenable` onto the memory bus, holds the request while `waitrequest` is high, and returns lane-extracted, sign- or zero-extended load data to the core. It is the master-side counterpart of the bench memory and of any bus slave the CPU talks to.

---
 rtl/mips_cpu_bus_pkg.sv | 37 +++
 rtl/mips_cpu_bus_lane_align.sv | 64 ++++++
 rtl/mips_cpu_bus_master.sv | 176 +++++++++++++++++
 tb/tb_mips_cpu_bus_master.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the MIPS CPU bus master.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mips_cpu_bus_pkg;

  // Access size as encoded on the core request port. Encoding 3 is unused
  // and is treated as a misaligned access by the lane aligner.
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } bus_state_t;

  // Byte-lane enables; lane k carries byte address (word base + k).
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  // Extend a byte to 32 bits; sign-extends only when is_signed is set.
  function automatic logic [31:0] ext8(input logic [7:0] b, input logic is_signed);
    return {{24{is_signed & b[7]}}, b};
  endfunction

  // Extend a halfword to 32 bits; sign-extends only when is_signed is set.
  function automatic logic [31:0] ext16(input logic [15:0] h, input logic is_signed);
    return {{16{is_signed & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mips_cpu_bus_lane_align.sv
// Lane steering: byteenable/writedata generation, load extraction, alignment check.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   size       - access size (0 byte, 1 half, 2 word, 3 illegal)
//   addr_lo    - low two bits of the byte address
//   is_signed  - sign-extend sub-word loads
//   wdata      - right-justified store data
//   readdata   - raw bus word
//   byteenable - active lanes for the access
//   writedata  - store data replicated into every candidate lane
//   rdata      - selected lane(s) of readdata, extended to 32 bits
//   misaligned - access cannot be issued as a single aligned bus word
module mips_cpu_bus_lane_align
  import mips_cpu_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata,
  output logic        misaligned
);

  // Readdata shifted so the addressed byte lands in bits [7:0].
  logic [31:0] byte_shifted;
  logic [15:0] half_sel;

  assign byte_shifted = readdata >> {addr_lo, 3'b000};
  assign half_sel     = addr_lo[1] ? readdata[31:16] : readdata[15:0];

  always_comb begin
    byteenable = 4'b0000;
    writedata  = wdata;
    rdata      = readdata;
    misaligned = 1'b0;
    case (size_t'(size))
      BYTE: begin
        byteenable = BE_BYTE << addr_lo;
        writedata  = {4{wdata[7:0]}};
        rdata      = ext8(byte_shifted[7:0], is_signed);
      end
      HALF: begin
        byteenable = addr_lo[1] ? BE_HI : BE_LO;
        writedata  = {2{wdata[15:0]}};
        rdata      = ext16(half_sel, is_signed);
        misaligned = addr_lo[0];
      end
      WORD: begin
        byteenable = BE_WORD;
        misaligned = |addr_lo;
      end
      default: begin
        // Encoding 3 has no defined width; reject it like a misaligned access.
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_master.sv
// Bus initiator for the MIPS core memory port: one load/store at a time.
// Latency: store 2 cycles accept->resp, load 3 cycles, +1 per waitrequest cycle; misaligned 1 cycle.
// Backpressure: req_ready only in IDLE; bus request held stable while waitrequest is high.
//
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   req_valid/req_ready   - core request handshake
//   req_write, req_size, req_signed, req_addr, req_wdata - request fields
//   resp_valid/resp_rdata/resp_err - one-cycle completion with load data or error
//   address, read, write, byteenable, writedata - bus request (all registered)
//   waitrequest, readdata - bus slave stall and read return data
module mips_cpu_bus_master
  import mips_cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic              waitrequest,
  input  logic [31:0]       readdata
);

  bus_state_t state_q, state_d;

  // Request fields kept for the load extraction at the end of the transfer.
  logic [1:0] size_q;
  logic [1:0] addr_lo_q;
  logic       signed_q;
  logic       wr_q;

  // Next values of the registered outputs and update strobes.
  logic read_d, write_d;
  logic resp_valid_d, resp_err_d;
  logic latch_req;
  logic load_rdata;

  // Aligner sees the live request while idle (to decide accept/reject and
  // build lanes) and the latched request afterwards (to extract load data).
  logic        sel_live;
  logic [1:0]  al_size;
  logic [1:0]  al_addr_lo;
  logic        al_signed;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_mis;

  assign sel_live   = (state_q == IDLE);
  assign al_size    = sel_live ? req_size     : size_q;
  assign al_addr_lo = sel_live ? req_addr[1:0] : addr_lo_q;
  assign al_signed  = sel_live ? req_signed   : signed_q;

  mips_cpu_bus_lane_align u_align (
    .size       (al_size),
    .addr_lo    (al_addr_lo),
    .is_signed  (al_signed),
    .wdata      (req_wdata),
    .readdata   (readdata),
    .byteenable (al_be),
    .writedata  (al_wdata),
    .rdata      (al_rdata),
    .misaligned (al_mis)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    read_d       = read;
    write_d      = write;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    latch_req    = 1'b0;
    load_rdata   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (al_mis) begin
            // Rejected without touching the bus.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d   = REQ;
            latch_req = 1'b1;
            read_d    = ~req_write;
            write_d   = req_write;
          end
        end
      end
      REQ: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (wr_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = RDATA;
          end
        end
      end
      RDATA: begin
        // Slave data is valid in this cycle; capture it on the way to RESP.
        state_d      = RESP;
        resp_valid_d = 1'b1;
        load_rdata   = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b1;
      read       <= 1'b0;
      write      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      address    <= '0;
      byteenable <= 4'b0000;
      writedata  <= 32'd0;
      size_q     <= 2'd0;
      addr_lo_q  <= 2'd0;
      signed_q   <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      req_ready  <= (state_d == IDLE);
      read       <= read_d;
      write      <= write_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      if (latch_req) begin
        address    <= {req_addr[ADDR_W-1:2], 2'b00};
        byteenable <= al_be;
        writedata  <= al_wdata;
        size_q     <= req_size;
        addr_lo_q  <= req_addr[1:0];
        signed_q   <= req_signed;
        wr_q       <= req_write;
      end
      // Load data persists until the next load completes.
      if (load_rdata) begin
        resp_rdata <= al_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
module tb_mips_cpu_bus_master;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic              waitrequest;
  logic [31:0]       readdata;

  always #5 clk = ~clk;

  mips_cpu_bus_master #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory (byte addressed, updated from request semantics) and
  // the slave's own memory (updated only by what appears on the bus).
  logic [7:0] ref_mem [256];
  logic [7:0] bus_mem [256];

  int force_left = 0;
  bit rand_ws    = 1'b0;

  // Last observed bus request / response, for literal expectations.
  logic [31:0] last_addr, last_wd, last_rdata;
  logic [3:0]  last_be;
  int          last_cyc, last_strobes;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Bus slave: sample mid-cycle, act just after the rising edge.
  bit          acc_rd = 1'b0, acc_wr = 1'b0;
  logic [31:0] s_addr, s_wd;
  logic [3:0]  s_be;

  always @(negedge clk) begin
    acc_rd = read && !waitrequest;
    acc_wr = write && !waitrequest;
    s_addr = address;
    s_be   = byteenable;
    s_wd   = writedata;
  end

  always @(posedge clk) begin
    #1;
    if (acc_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (s_be[k]) bus_mem[8'(s_addr[7:0] + k)] = s_wd[8*k +: 8];
      end
    end
    if (acc_rd) begin
      readdata = {bus_mem[8'(s_addr[7:0] + 3)], bus_mem[8'(s_addr[7:0] + 2)],
                  bus_mem[8'(s_addr[7:0] + 1)], bus_mem[s_addr[7:0]]};
    end else begin
      readdata = $urandom;
    end
    acc_rd = 1'b0;
    acc_wr = 1'b0;
    if (force_left > 0 && (read || write)) begin
      waitrequest = 1'b1;
      force_left--;
    end else if (rand_ws) begin
      waitrequest = ($urandom_range(0, 2) == 0);
    end else begin
      waitrequest = 1'b0;
    end
  end

  // One request through the DUT, checked every cycle against expectations
  // derived from the byte-level meaning of the request.
  task automatic xact(input bit w, input logic [1:0] sz, input bit sg,
                      input logic [31:0] a, input logic [31:0] wd, input int forced);
    int          n, lo, cyc, waits, strobes, lat_exp;
    bit          mis, got;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd, eaddr;

    n     = 1 << sz;
    lo    = int'(a[1:0]);
    mis   = (sz == 2'd3) || ((a & 32'(n - 1)) != 0);
    eaddr = a & ~32'd3;
    for (int k = 0; k < 4; k++) begin
      ebe[k]        = (k >= lo) && (k < lo + n);
      ewd[8*k +: 8] = wd[8*(k % n) +: 8];
    end
    erd = 32'd0;
    if (!mis) begin
      for (int i = 0; i < n; i++) erd |= 32'(ref_mem[8'(a[7:0] + i)]) << (8 * i);
      if (sg && n < 4 && erd[8*n-1]) erd |= ~((32'd1 << (8 * n)) - 32'd1);
      if (w) for (int i = 0; i < n; i++) ref_mem[8'(a[7:0] + i)] = wd[8*i +: 8];
    end

    @(negedge clk);
    chk("ready_before", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    force_left = forced;
    @(negedge clk);
    // Scramble the request fields to show the DUT works from latched copies.
    req_valid  = 1'b0;
    req_write  = $urandom_range(0, 1);
    req_size   = 2'($urandom);
    req_signed = $urandom_range(0, 1);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    cyc = 1; waits = 0; strobes = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      if (resp_valid) begin
        got = 1'b1;
      end else begin
        if (read || write) begin
          strobes++;
          chk("strobe_kind", {read, write}, w ? 2'b01 : 2'b10);
          chk("bus_address", address, eaddr);
          chk("bus_be", byteenable, ebe);
          if (w) chk("bus_writedata", writedata, ewd);
          if (waitrequest) waits++;
          last_addr = address;
          last_be   = byteenable;
          last_wd   = writedata;
        end
        @(negedge clk);
        cyc++;
      end
    end

    if (!got) begin
      chk("resp_timeout", 32'd0, 32'd1);
    end else begin
      lat_exp = mis ? 1 : ((w ? 2 : 3) + waits);
      chk("resp_latency", cyc, lat_exp);
      chk("strobe_cycles", strobes, mis ? 0 : waits + 1);
      chk("resp_err", resp_err, mis);
      if (!w && !mis) chk("resp_rdata", resp_rdata, erd);
    end
    last_rdata   = resp_rdata;
    last_cyc     = cyc;
    last_strobes = strobes;
    @(negedge clk);
    chk("resp_one_cycle", resp_valid, 1'b0);
    chk("ready_after", req_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'h00;
      bus_mem[i] = 8'h00;
    end
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'd0;
    req_signed  = 1'b0;
    req_addr    = '0;
    req_wdata   = 32'd0;
    waitrequest = 1'b0;
    readdata    = 32'd0;

    @(negedge clk);
    chk("rst_read", read, 1'b0);
    chk("rst_write", write, 1'b0);
    chk("rst_be", byteenable, 4'b0000);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_req_ready", req_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases with hand-computed literal results.
    xact(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0);
    chk("sw_addr_lit", last_addr, 32'h100);
    chk("sw_be_lit", last_be, 4'b1111);
    chk("sw_wd_lit", last_wd, 32'hDEADBEEF);
    chk("sw_cyc_lit", last_cyc, 2);
    xact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
    chk("lw_data_lit", last_rdata, 32'hDEADBEEF);
    chk("lw_cyc_lit", last_cyc, 3);

    xact(1'b1, 2'd0, 1'b0, 32'h102, 32'h123456A5, 0);
    chk("sb_addr_lit", last_addr, 32'h100);
    chk("sb_be_lit", last_be, 4'b0100);
    chk("sb_wd_lit", last_wd, 32'hA5A5A5A5);
    xact(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 0);
    chk("lb_lit", last_rdata, 32'hFFFFFFA5);
    xact(1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 0);
    chk("lbu_lit", last_rdata, 32'h000000A5);

    xact(1'b1, 2'd1, 1'b0, 32'h106, 32'hABCD8001, 0);
    chk("sh_addr_lit", last_addr, 32'h104);
    chk("sh_be_lit", last_be, 4'b1100);
    chk("sh_wd_lit", last_wd, 32'h80018001);
    xact(1'b0, 2'd1, 1'b1, 32'h106, 32'h0, 0);
    chk("lh_lit", last_rdata, 32'hFFFF8001);
    xact(1'b0, 2'd1, 1'b0, 32'h106, 32'h0, 0);
    chk("lhu_lit", last_rdata, 32'h00008001);

    xact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3);
    chk("lw_wait_cyc_lit", last_cyc, 6);
    chk("lw_wait_strobes_lit", last_strobes, 4);
    chk("lw_wait_data_lit", last_rdata, 32'hDEA5BEEF);

    xact(1'b0, 2'd1, 1'b1, 32'h101, 32'h0, 0);
    chk("lh_mis_cyc_lit", last_cyc, 1);
    chk("lh_mis_strobes_lit", last_strobes, 0);
    xact(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0);
    chk("lw_mis_cyc_lit", last_cyc, 1);
    chk("lw_mis_strobes_lit", last_strobes, 0);
    xact(1'b1, 2'd3, 1'b0, 32'h100, 32'h55, 0);
    chk("size3_mis_cyc_lit", last_cyc, 1);

    // Reset while a read is stalled on the bus.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h100;
    force_left = 1000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_read_before", read, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_read", read, 1'b0);
    chk("rst_mid_write", write, 1'b0);
    chk("rst_mid_ready", req_ready, 1'b1);
    chk("rst_mid_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    reset      = 1'b0;
    force_left = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_resp", resp_valid, 1'b0);
      chk("rst_no_strobe", {read, write}, 2'b00);
    end
    xact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
    chk("post_rst_lw_lit", last_rdata, 32'hDEA5BEEF);
    chk("post_rst_lw_cyc_lit", last_cyc, 3);

    // Random traffic with random slave stalls.
    rand_ws = 1'b1;
    for (int t = 0; t < 300; t++) begin
      bit          w, sg;
      logic [1:0]  sz;
      logic [31:0] a;
      w  = $urandom_range(0, 1);
      sg = $urandom_range(0, 1);
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      xact(w, sz, sg, a, $urandom, 0);
    end
    rand_ws = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
